seg7_counter_n: RTL and testbench

- Parametrised N-digit decimal counter with a direct 7-segment drive per digit.
- Successor to the fixed 3-digit 1 Hz seconds display. Adds:
  - configurable digit count;
  - on-chip tick prescaler, so it runs from a fast system clock;
  - up/down counting and synchronous BCD preload;
  - wrap/borrow pulse for cascading;
  - selectable segment polarity.
- Sits between the system clock domain and the board's 7-segment pins.

---
 rtl/seg7_counter_n_if.sv | 23 ++
 rtl/seg7_counter_n.sv | 128 ++++++++++++
 tb/tb_seg7_counter_n.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_counter_n_if.sv
// Control and display bundle for seg7_counter_n. The master drives en, up_dn, load and load_val.
// The slave (the counter) drives bcd, seg and wrap.
interface seg7_counter_n_if #(
    parameter int NUM_DIGITS = 3
);
    logic                    en;
    logic                    up_dn;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] load_val;
    logic [4*NUM_DIGITS-1:0] bcd;
    logic [8*NUM_DIGITS-1:0] seg;
    logic                    wrap;

    modport master (
        output en, up_dn, load, load_val,
        input  bcd, seg, wrap
    );

    modport slave (
        input  en, up_dn, load, load_val,
        output bcd, seg, wrap
    );
endinterface

// File: rtl/seg7_counter_n.sv
// N-digit up/down BCD counter with a tick prescaler and 7-segment drive. bcd, seg and wrap are registered and
// change together one edge after a tick or load; there is no backpressure. SEG7_BLANK_LEADING_ZERO_EN blanks leading zeros.
module seg7_counter_n #(
    parameter int NUM_DIGITS     = 3,
    parameter int CLK_DIV        = 1,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    seg7_counter_n_if.slave   bus
);
    localparam int BW = 4 * NUM_DIGITS;
    localparam int SW = 8 * NUM_DIGITS;
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] bcd_q, bcd_d;
    logic [SW-1:0] seg_q;
    logic          wrap_q, wrap_d;
    logic          tick;
    logic          carry;
    logic [3:0]    dig;

    function automatic logic [7:0] decode_digit(input logic [3:0] d);
        logic [7:0] p;
        case (d)
            4'd0:    p = 8'h3F;
            4'd1:    p = 8'h06;
            4'd2:    p = 8'h5B;
            4'd3:    p = 8'h4F;
            4'd4:    p = 8'h66;
            4'd5:    p = 8'h6D;
            4'd6:    p = 8'h7D;
            4'd7:    p = 8'h07;
            4'd8:    p = 8'h7F;
            4'd9:    p = 8'h6F;
            default: p = 8'h00;
        endcase
        return p;
    endfunction

    function automatic logic [SW-1:0] encode(input logic [BW-1:0] v);
        logic [SW-1:0] enc;
        logic [7:0]    pat;
        logic [3:0]    d;
`ifdef SEG7_BLANK_LEADING_ZERO_EN
        logic          higher_zero;
        higher_zero = 1'b1;
`endif
        enc = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            d   = v[4*i +: 4];
            pat = decode_digit(d);
`ifdef SEG7_BLANK_LEADING_ZERO_EN
            // Digit 0 always shows, so a zero count still reads as "0".
            if ((i > 0) && higher_zero && (d == 4'd0)) begin
                pat = 8'h00;
            end
            higher_zero = higher_zero & (d == 4'd0);
`endif
            enc[8*i +: 8] = SEG_ACTIVE_LOW ? ~pat : pat;
        end
        return enc;
    endfunction

    assign tick = bus.en && (presc_q == PRESC_LAST);

    always_comb begin
        presc_d = presc_q;
        bcd_d   = bcd_q;
        wrap_d  = 1'b0;
        carry   = 1'b1;
        dig     = 4'd0;
        if (bus.load) begin
            presc_d = '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                dig = bus.load_val[4*i +: 4];
                bcd_d[4*i +: 4] = (dig > 4'd9) ? 4'd0 : dig;
            end
        end else if (tick) begin
            presc_d = '0;
            // carry doubles as borrow; whatever leaves the top digit is the wrap.
            for (int i = 0; i < NUM_DIGITS; i++) begin
                dig = bcd_q[4*i +: 4];
                if (carry) begin
                    if (bus.up_dn) begin
                        if (dig == 4'd9) begin
                            dig = 4'd0;
                        end else begin
                            dig   = dig + 4'd1;
                            carry = 1'b0;
                        end
                    end else begin
                        if (dig == 4'd0) begin
                            dig = 4'd9;
                        end else begin
                            dig   = dig - 4'd1;
                            carry = 1'b0;
                        end
                    end
                end
                bcd_d[4*i +: 4] = dig;
            end
            wrap_d = carry;
        end else if (bus.en) begin
            presc_d = presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            bcd_q   <= '0;
            wrap_q  <= 1'b0;
            seg_q   <= encode({BW{1'b0}});
        end else begin
            presc_q <= presc_d;
            bcd_q   <= bcd_d;
            wrap_q  <= wrap_d;
            seg_q   <= encode(bcd_d);
        end
    end

    assign bus.bcd  = bcd_q;
    assign bus.seg  = seg_q;
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_seg7_counter_n.sv
// Directed bench for seg7_counter_n: an integer-count model is compared against two instances every cycle.
// The instances are active-high and active-low, and both receive the same stimulus.
module tb_seg7_counter_n;
    localparam int ND   = 3;
    localparam int DIV  = 4;
    localparam int MAXV = 1000;
    localparam logic [7:0] SEG_TBL [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                           8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    seg7_counter_n_if #(.NUM_DIGITS(ND)) bus();
    seg7_counter_n_if #(.NUM_DIGITS(ND)) bus_al();

    assign bus_al.en       = bus.en;
    assign bus_al.up_dn    = bus.up_dn;
    assign bus_al.load     = bus.load;
    assign bus_al.load_val = bus.load_val;

    seg7_counter_n #(.NUM_DIGITS(ND), .CLK_DIV(DIV), .SEG_ACTIVE_LOW(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    seg7_counter_n #(.NUM_DIGITS(ND), .CLK_DIV(DIV), .SEG_ACTIVE_LOW(1'b1)) dut_al (
        .clk (clk),
        .rst (rst),
        .bus (bus_al)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] int_to_bcd(int v);
        logic [11:0] r;
        for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
        return r;
    endfunction

    function automatic int bcd_to_int(logic [11:0] b);
        int v = 0;
        int d;
        for (int i = 0; i < ND; i++) begin
            d = int'(b[4*i +: 4]);
            if (d > 9) d = 0;
            v += d * (10 ** i);
        end
        return v;
    endfunction

    function automatic logic [23:0] seg_exp(int v, bit al);
        logic [23:0] r;
        logic [7:0]  p;
        for (int i = 0; i < ND; i++) begin
            p = SEG_TBL[(v / (10 ** i)) % 10];
`ifdef SEG7_BLANK_LEADING_ZERO_EN
            if (i > 0 && v < 10 ** i) p = 8'h00;
`endif
            r[8*i +: 8] = al ? ~p : p;
        end
        return r;
    endfunction

    // Model: the count is a plain integer; the prescaler is a plain cycle counter.
    int m_cnt = 0;
    int m_presc = 0;
    bit m_wrap = 1'b0;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        int c;
        int p;
        bit w;
        c = m_cnt;
        p = m_presc;
        w = 1'b0;
        if (rst) begin
            c = 0;
            p = 0;
        end else if (bus.load) begin
            c = bcd_to_int(bus.load_val);
            p = 0;
        end else if (bus.en) begin
            if (p == DIV - 1) begin
                p = 0;
                if (bus.up_dn) begin
                    c = c + 1;
                    if (c == MAXV) begin c = 0; w = 1'b1; end
                end else if (c == 0) begin
                    c = MAXV - 1;
                    w = 1'b1;
                end else begin
                    c = c - 1;
                end
            end else begin
                p = p + 1;
            end
        end
        m_cnt   <= c;
        m_presc <= p;
        m_wrap  <= w;
        if (rst) m_valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            checks += 4;
            if (bus.bcd !== int_to_bcd(m_cnt)) begin
                errors++;
                $display("FAIL model_bcd t=%0t got %h want %h", $time, bus.bcd, int_to_bcd(m_cnt));
            end
            if (bus.wrap !== m_wrap) begin
                errors++;
                $display("FAIL model_wrap t=%0t got %b want %b", $time, bus.wrap, m_wrap);
            end
            if (bus.seg !== seg_exp(m_cnt, 1'b0)) begin
                errors++;
                $display("FAIL model_seg t=%0t got %h want %h", $time, bus.seg, seg_exp(m_cnt, 1'b0));
            end
            if (bus_al.seg !== seg_exp(m_cnt, 1'b1)) begin
                errors++;
                $display("FAIL model_seg_al t=%0t got %h want %h", $time, bus_al.seg, seg_exp(m_cnt, 1'b1));
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic load_cycle(input logic [11:0] v);
        bus.load     = 1'b1;
        bus.load_val = v;
        @(negedge clk);
        bus.load     = 1'b0;
    endtask

    localparam logic [23:0] SEG_ZERO    = 24'h3F3F3F;
    localparam logic [23:0] SEG_ZERO_AL = 24'hC0C0C0;
`ifdef SEG7_BLANK_LEADING_ZERO_EN
    localparam logic [23:0] RST_SEG     = 24'h00003F;
    localparam logic [23:0] RST_SEG_AL  = 24'hFFFFC0;
    localparam logic [23:0] SEG_007     = 24'h000007;
    localparam logic [23:0] SEG_042_AL  = 24'hFF99A4;
`else
    localparam logic [23:0] RST_SEG     = SEG_ZERO;
    localparam logic [23:0] RST_SEG_AL  = SEG_ZERO_AL;
    localparam logic [23:0] SEG_007     = 24'h3F3F07;
    localparam logic [23:0] SEG_042_AL  = 24'hC099A4;
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.en       = 1'b0;
        bus.up_dn    = 1'b1;
        bus.load     = 1'b0;
        bus.load_val = '0;
        repeat (2) @(negedge clk);
        chk("rst_bcd", 32'(bus.bcd), 32'h000);
        chk("rst_wrap", 32'(bus.wrap), 32'h0);
        chk("rst_seg", 32'(bus.seg), 32'(RST_SEG));
        chk("rst_seg_al", 32'(bus_al.seg), 32'(RST_SEG_AL));

        // Plain up count: 40 enabled cycles at divide-by-4 is ten steps.
        rst    = 1'b0;
        bus.en = 1'b1;
        repeat (40) @(negedge clk);
        chk("up40_bcd", 32'(bus.bcd), 32'h010);
        chk("up40_seg0", 32'(bus.seg[7:0]), 32'h3F);
        chk("up40_seg1", 32'(bus.seg[15:8]), 32'h06);

        // Up wrap through 999.
        load_cycle(12'h998);
        chk("ld998_bcd", 32'(bus.bcd), 32'h998);
        repeat (4) @(negedge clk);
        chk("up999_bcd", 32'(bus.bcd), 32'h999);
        chk("up999_wrap", 32'(bus.wrap), 32'h0);
        repeat (4) @(negedge clk);
        chk("upwrap_bcd", 32'(bus.bcd), 32'h000);
        chk("upwrap_wrap", 32'(bus.wrap), 32'h1);
        chk("upwrap_seg", 32'(bus.seg), 32'(SEG_ZERO));
        @(negedge clk);
        chk("upwrap_pulse_end", 32'(bus.wrap), 32'h0);

        // Down borrow through 000.
        bus.up_dn = 1'b0;
        load_cycle(12'h000);
        repeat (4) @(negedge clk);
        chk("dnwrap_bcd", 32'(bus.bcd), 32'h999);
        chk("dnwrap_wrap", 32'(bus.wrap), 32'h1);
        chk("dnwrap_seg", 32'(bus.seg), 32'h6F6F6F);

        // Freeze mid-prescale; two prescale cycles remain after re-enable.
        repeat (2) @(negedge clk);
        bus.en = 1'b0;
        repeat (10) @(negedge clk);
        chk("frozen_bcd", 32'(bus.bcd), 32'h999);
        bus.en = 1'b1;
        @(negedge clk);
        chk("resume1_bcd", 32'(bus.bcd), 32'h999);
        @(negedge clk);
        chk("resume2_bcd", 32'(bus.bcd), 32'h998);

        // Load collides with a tick and wins; the invalid digit becomes 0.
        repeat (3) @(negedge clk);
        load_cycle(12'h1A5);
        chk("ldtick_bcd", 32'(bus.bcd), 32'h105);
        chk("ldtick_wrap", 32'(bus.wrap), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst2_bcd", 32'(bus.bcd), 32'h000);
        chk("rst2_wrap", 32'(bus.wrap), 32'h0);
        chk("rst2_seg", 32'(bus.seg), 32'(RST_SEG));

        // Display patterns, including the active-low instance.
        bus.en = 1'b0;
        load_cycle(12'h007);
        chk("seg_007", 32'(bus.seg), 32'(SEG_007));
        load_cycle(12'h042);
        chk("seg_042_al", 32'(bus_al.seg), 32'(SEG_042_AL));

        // Carry and borrow across the middle digit.
        bus.en    = 1'b1;
        bus.up_dn = 1'b1;
        load_cycle(12'h099);
        repeat (4) @(negedge clk);
        chk("carry_bcd", 32'(bus.bcd), 32'h100);
        bus.up_dn = 1'b0;
        repeat (4) @(negedge clk);
        chk("borrow_bcd", 32'(bus.bcd), 32'h099);
        repeat (8) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
